bg_char_fetch_pipe: RTL and testbench
=====================================

BG_CHAR_FETCH_PIPE -- requirements
Module: bg_char_fetch_pipe

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 17, VRAM byte-address width; BASE_SHIFT, default 14, log2 of the char-base block size in bytes.
REQ-002 clock  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  pixel fetch request present.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 screendata  input  16  text-mode map entry: [9:0] char name, [10] hflip, [11] vflip, [15:12] palette bank.
REQ-007 charbase  input  2  char-base block number.
REQ-008 x, y  input  3 each  pixel position within the 8x8 tile.
REQ-009 rotate  input  1  affine mode: name = screendata[7:0]; no flips, no bank; 8bpp forced.
REQ-010 palettemode  input  1  0 = 4bpp, 1 = 8bpp; ignored when rotate=1.
REQ-011 flush  input  1  abort the request in flight.
REQ-012 mem_req  output  1  VRAM read request.
REQ-013 mem_addr  output  ADDR_W-1  halfword address.
REQ-014 mem_gnt  input  1  request accepted this cycle.
REQ-015 mem_rvalid  input  1  read data valid.
REQ-016 mem_rdata  input  16  read halfword.
REQ-017 out_valid  output  1  pixel result valid.
REQ-018 out_ready  input  1  consumer accepts the result.
REQ-019 pix_index  output  8  palette index.
REQ-020 pix_transparent  output  1  the raw colour field is zero.

Function
REQ-021 The FSM SHALL have four states: IDLE, REQ, WAIT, OUT. It SHALL also have a DRAIN state that is entered only on flush.
REQ-022 in_ready SHALL equal 1 only in IDLE; a request is accepted on in_valid&&in_ready, and all request inputs are latched in that cycle.
REQ-023 Effective fields: x' = hflip ? 7-x : x, and y' = vflip ? 7-y : y; flips SHALL be treated as 0 when rotate=1.
REQ-024 Byte address (mod 2^ADDR_W) SHALL be charbase<<BASE_SHIFT plus one of: 4bpp, name*32 + y'*4 + x'[2:1]; 8bpp, name*64 + y'*8 + x'.
REQ-025 mem_addr SHALL equal byte address[ADDR_W-1:1] and be registered; byte select = byte address[0] (1 = mem_rdata[15:8]).
REQ-026 Timing: IDLE->REQ on accept; mem_req=1 and mem_addr stable from the next cycle until mem_gnt.
REQ-027 Transitions: REQ->WAIT on mem_gnt; WAIT->OUT on mem_rvalid, capturing the selected byte.
REQ-028 mem_rvalid in IDLE, REQ or OUT SHALL be ignored.
REQ-029 4bpp output: nibble = x'[0] ? byte[7:4] : byte[3:0]; pix_index = {bank, nibble}; transparent = (nibble==0).
REQ-030 8bpp/affine output: pix_index = byte; transparent = (byte==0).
REQ-031 OUT: out_valid=1 with outputs held stable until out_ready, then OUT->IDLE; a new request SHALL be accepted no earlier than the following cycle.
REQ-032 Flush in REQ: go to IDLE; mem_req drops next cycle.
REQ-033 Flush in REQ with mem_gnt the same cycle: go to DRAIN.
REQ-034 Flush in WAIT: go to DRAIN; flush in WAIT with mem_rvalid the same cycle: go to IDLE, data discarded.
REQ-035 Flush in OUT: go to IDLE, result dropped.
REQ-036 DRAIN: in_ready=0; leave on mem_rvalid to IDLE, data discarded.
REQ-037 Flush in IDLE SHALL have no effect, and an in_valid in the same cycle SHALL be rejected.
REQ-038 Minimum latency accept->out_valid SHALL be 3 cycles (gnt in first REQ cycle, rvalid next cycle).

Reset
REQ-039 Reset SHALL force IDLE and clear these outputs to 0: in_ready, mem_req, mem_addr, out_valid, pix_index, pix_transparent.
REQ-040 in_ready SHALL become 1 in the first cycle after reset deasserts.
REQ-041 Reset SHALL override flush and all handshakes; reset mid-transaction SHALL ignore a later mem_rvalid.

Verification
REQ-042 Case 4bpp with flips: screendata=0x3C05, charbase=1, x=1, y=2, pm=0. Required: mem_addr=0x205B; rdata=0xA5C3 -> pix_index=0x35, transparent=0.
REQ-043 Case 8bpp upper limit: screendata=0x03FF, charbase=0, x=7, y=7, pm=1. Required: mem_addr=0x7FFF; rdata=0x00FF -> pix_index=0x00, transparent=1.
REQ-044 Case affine: rotate=1, screendata=0xFF12, x=3, y=4. Required: mem_addr=0x0251, high byte; rdata=0x7E00 -> pix_index=0x7E.
REQ-045 Case backpressure: hold mem_gnt=0 5 cycles and out_ready=0 4 cycles. Required: mem_addr and pix_index stable; in_ready=0 throughout.
REQ-046 Case flush in WAIT: state becomes DRAIN; the next mem_rvalid gives no out_valid; in_ready=1 the following cycle.
REQ-047 Case reset asserted in REQ: all outputs 0 next cycle; a stray mem_rvalid afterwards produces no out_valid.

Source files
------------

// File: rtl/bg_char_fetch_pipe_if.sv
// Request, VRAM and pixel-result handshake bundle for the background char fetch pipe.
// The slave modport is the fetch block's view; the master modport is the surrounding system's view.
interface bg_char_fetch_pipe_if #(
    parameter int ADDR_W = 17
);
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       screendata;
    logic [1:0]        charbase;
    logic [2:0]        x;
    logic [2:0]        y;
    logic              rotate;
    logic              palettemode;
    logic              flush;
    logic              mem_req;
    logic [ADDR_W-2:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [15:0]       mem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        pix_index;
    logic              pix_transparent;

    modport slave (
        input  in_valid, screendata, charbase, x, y, rotate, palettemode, flush,
        input  mem_gnt, mem_rvalid, mem_rdata, out_ready,
        output in_ready, mem_req, mem_addr, out_valid, pix_index, pix_transparent
    );

    modport master (
        output in_valid, screendata, charbase, x, y, rotate, palettemode, flush,
        output mem_gnt, mem_rvalid, mem_rdata, out_ready,
        input  in_ready, mem_req, mem_addr, out_valid, pix_index, pix_transparent
    );
endinterface

// File: rtl/bg_char_fetch_pipe.sv
// Background character pixel fetch: turns a map entry plus tile position into one VRAM
// halfword read and extracts the palette index of that pixel (4bpp, 8bpp or affine).
module bg_char_fetch_pipe #(
    parameter int ADDR_W     = 17,
    parameter int BASE_SHIFT = 14
) (
    input  logic clock,
    input  logic reset,
    bg_char_fetch_pipe_if.slave bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_OUT   = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]        state_r;
    logic [2:0]        state_next_s;
    logic              in_ready_r;
    logic              mem_req_r;
    logic [ADDR_W-2:0] mem_addr_r;
    logic              out_valid_r;
    logic [7:0]        pix_index_r;
    logic              pix_transparent_r;

    logic              byte_sel_r;
    logic              x_lsb_r;
    logic [3:0]        bank_r;
    logic              bpp8_r;

    logic              accept_s;
    logic              capture_s;
    logic              hflip_s;
    logic              vflip_s;
    logic              bpp8_s;
    logic [9:0]        name_s;
    logic [2:0]        x_eff_s;
    logic [2:0]        y_eff_s;
    logic [ADDR_W-1:0] offset_s;
    logic [ADDR_W-1:0] byte_addr_s;
    logic [7:0]        byte_s;
    logic [3:0]        nibble_s;
    logic [7:0]        pix_s;
    logic              trans_s;

    // A flush in IDLE also blocks a same-cycle request.
    assign accept_s  = bus.in_valid && in_ready_r && !bus.flush;
    assign capture_s = (state_r == S_WAIT) && bus.mem_rvalid && !bus.flush;

    // Decode the map entry and form the byte address (all arithmetic wraps at ADDR_W bits).
    always_comb begin
        if (bus.rotate) begin
            name_s  = {2'b00, bus.screendata[7:0]};
            hflip_s = 1'b0;
            vflip_s = 1'b0;
            bpp8_s  = 1'b1;
        end else begin
            name_s  = bus.screendata[9:0];
            hflip_s = bus.screendata[10];
            vflip_s = bus.screendata[11];
            bpp8_s  = bus.palettemode;
        end
        x_eff_s = hflip_s ? (3'd7 - bus.x) : bus.x;
        y_eff_s = vflip_s ? (3'd7 - bus.y) : bus.y;
        if (bpp8_s) begin
            offset_s = (ADDR_W'(name_s) << 6) + (ADDR_W'(y_eff_s) << 3) + ADDR_W'(x_eff_s);
        end else begin
            offset_s = (ADDR_W'(name_s) << 5) + (ADDR_W'(y_eff_s) << 2) + ADDR_W'(x_eff_s[2:1]);
        end
        byte_addr_s = (ADDR_W'(bus.charbase) << BASE_SHIFT) + offset_s;
    end

    // Pick the addressed byte and, in 4bpp, the addressed nibble.
    always_comb begin
        byte_s   = byte_sel_r ? bus.mem_rdata[15:8] : bus.mem_rdata[7:0];
        nibble_s = x_lsb_r ? byte_s[7:4] : byte_s[3:0];
        if (bpp8_r) begin
            pix_s   = byte_s;
            trans_s = (byte_s == 8'd0);
        end else begin
            pix_s   = {bank_r, nibble_s};
            trans_s = (nibble_s == 4'd0);
        end
    end

    // Next-state logic; flush wins over the normal handshake in every busy state.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) state_next_s = S_REQ;
                else          state_next_s = S_IDLE;
            end
            S_REQ: begin
                if (bus.flush)        state_next_s = bus.mem_gnt ? S_DRAIN : S_IDLE;
                else if (bus.mem_gnt) state_next_s = S_WAIT;
                else                  state_next_s = S_REQ;
            end
            S_WAIT: begin
                if (bus.flush)           state_next_s = bus.mem_rvalid ? S_IDLE : S_DRAIN;
                else if (bus.mem_rvalid) state_next_s = S_OUT;
                else                     state_next_s = S_WAIT;
            end
            S_OUT: begin
                if (bus.flush || bus.out_ready) state_next_s = S_IDLE;
                else                            state_next_s = S_OUT;
            end
            S_DRAIN: begin
                if (bus.mem_rvalid) state_next_s = S_IDLE;
                else                state_next_s = S_DRAIN;
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // State, registered handshake outputs and latched request fields.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r           <= S_IDLE;
            in_ready_r        <= 1'b0;
            mem_req_r         <= 1'b0;
            mem_addr_r        <= '0;
            out_valid_r       <= 1'b0;
            pix_index_r       <= 8'd0;
            pix_transparent_r <= 1'b0;
            byte_sel_r        <= 1'b0;
            x_lsb_r           <= 1'b0;
            bank_r            <= 4'd0;
            bpp8_r            <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s == S_IDLE);
            mem_req_r   <= (state_next_s == S_REQ);
            out_valid_r <= (state_next_s == S_OUT);
            if (accept_s) begin
                mem_addr_r <= byte_addr_s[ADDR_W-1:1];
                byte_sel_r <= byte_addr_s[0];
                x_lsb_r    <= x_eff_s[0];
                bank_r     <= bus.screendata[15:12];
                bpp8_r     <= bpp8_s;
            end
            if (capture_s) begin
                pix_index_r       <= pix_s;
                pix_transparent_r <= trans_s;
            end
        end
    end

    assign bus.in_ready        = in_ready_r;
    assign bus.mem_req         = mem_req_r;
    assign bus.mem_addr        = mem_addr_r;
    assign bus.out_valid       = out_valid_r;
    assign bus.pix_index       = pix_index_r;
    assign bus.pix_transparent = pix_transparent_r;

endmodule

// File: tb/tb_bg_char_fetch_pipe.sv
// Directed bench for bg_char_fetch_pipe: hand-computed address/pixel vectors, backpressure,
// flush in each state and reset mid-transaction.
module tb_bg_char_fetch_pipe;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_err = 0;
    int   n_chk = 0;

    bg_char_fetch_pipe_if #(.ADDR_W(17)) bus ();

    bg_char_fetch_pipe #(.ADDR_W(17), .BASE_SHIFT(14)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [15:0] sd, input logic [1:0] cb, input logic [2:0] px,
                           input logic [2:0] py, input logic rot, input logic pm);
        bus.screendata  = sd;
        bus.charbase    = cb;
        bus.x           = px;
        bus.y           = py;
        bus.rotate      = rot;
        bus.palettemode = pm;
    endtask

    // Accept, check address, grant, return data, check pixel, consume.
    task automatic run_txn(input string tag, input logic [15:0] exp_addr, input logic [15:0] rdata,
                           input logic [7:0] exp_pix, input logic exp_tr);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk({tag, "_req"}, {31'd0, bus.mem_req}, 32'd1);
        chk({tag, "_addr"}, {16'd0, bus.mem_addr}, {16'd0, exp_addr});
        chk({tag, "_rdy_busy"}, {31'd0, bus.in_ready}, 32'd0);
        bus.mem_gnt = 1'b1;
        step();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rdata;
        step();
        bus.mem_rvalid = 1'b0;
        chk({tag, "_ovalid"}, {31'd0, bus.out_valid}, 32'd1);
        chk({tag, "_pix"}, {24'd0, bus.pix_index}, {24'd0, exp_pix});
        chk({tag, "_trans"}, {31'd0, bus.pix_transparent}, {31'd0, exp_tr});
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk({tag, "_done"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, "_rdy_back"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.flush      = 1'b0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 16'h0000;
        bus.out_ready  = 1'b0;
        set_req(16'h0000, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0);

        step();
        step();
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_pix", {24'd0, bus.pix_index}, 32'd0);
        chk("rst_trans", {31'd0, bus.pix_transparent}, 32'd0);
        reset = 1'b0;
        step();
        chk("post_rst_ready", {31'd0, bus.in_ready}, 32'd1);

        // 4bpp with both flips: x'=6, y'=5, byte 0x40B7 -> high byte 0xA5, low nibble 5.
        set_req(16'h3C05, 2'd1, 3'd1, 3'd2, 1'b0, 1'b0);
        run_txn("flip4", 16'h205B, 16'hA5C3, 8'h35, 1'b0);

        // 8bpp top of char space: byte 0xFFFF -> high byte 0x00.
        set_req(16'h03FF, 2'd0, 3'd7, 3'd7, 1'b0, 1'b1);
        run_txn("max8", 16'h7FFF, 16'h00FF, 8'h00, 1'b1);

        // Affine: name 0x12, flips/bank bits ignored, byte 0x4A3.
        set_req(16'hFF12, 2'd0, 3'd3, 3'd4, 1'b1, 1'b0);
        run_txn("affine", 16'h0251, 16'h7E00, 8'h7E, 1'b0);

        // 4bpp odd x: byte 0x8021, high byte 0x0F, upper nibble 0 -> transparent, bank kept.
        set_req(16'h5001, 2'd2, 3'd3, 3'd0, 1'b0, 1'b0);
        run_txn("odd4", 16'h4010, 16'h0F12, 8'h50, 1'b1);

        // Backpressure on grant and on result; stray rvalid in REQ ignored.
        set_req(16'h3C05, 2'd1, 3'd1, 3'd2, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.mem_rvalid = (i == 2);
            bus.mem_rdata  = 16'h1111;
            chk("bp_gnt_req", {31'd0, bus.mem_req}, 32'd1);
            chk("bp_gnt_addr", {16'd0, bus.mem_addr}, 32'h205B);
            chk("bp_gnt_rdy", {31'd0, bus.in_ready}, 32'd0);
            step();
        end
        bus.mem_rvalid = 1'b0;
        chk("bp_rvalid_ignored", {31'd0, bus.out_valid}, 32'd0);
        bus.mem_gnt = 1'b1;
        step();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 16'hA5C3;
        step();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("bp_out_pix", {24'd0, bus.pix_index}, 32'h35);
            chk("bp_out_rdy", {31'd0, bus.in_ready}, 32'd0);
            step();
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("bp_release", {31'd0, bus.out_valid}, 32'd0);

        // Flush in WAIT -> DRAIN; the late rvalid is swallowed.
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.mem_gnt  = 1'b1;
        step();
        bus.mem_gnt = 1'b0;
        bus.flush   = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("drain_rdy", {31'd0, bus.in_ready}, 32'd0);
        chk("drain_req", {31'd0, bus.mem_req}, 32'd0);
        step();
        chk("drain_hold_rdy", {31'd0, bus.in_ready}, 32'd0);
        bus.mem_rvalid = 1'b1;
        step();
        bus.mem_rvalid = 1'b0;
        chk("drain_exit_ovalid", {31'd0, bus.out_valid}, 32'd0);
        chk("drain_exit_rdy", {31'd0, bus.in_ready}, 32'd1);

        // Flush in WAIT together with rvalid -> straight to IDLE.
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.mem_gnt  = 1'b1;
        step();
        bus.mem_gnt    = 1'b0;
        bus.flush      = 1'b1;
        bus.mem_rvalid = 1'b1;
        step();
        bus.flush      = 1'b0;
        bus.mem_rvalid = 1'b0;
        chk("wflush_rv_rdy", {31'd0, bus.in_ready}, 32'd1);
        chk("wflush_rv_ovalid", {31'd0, bus.out_valid}, 32'd0);

        // Flush in REQ -> IDLE, mem_req drops.
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("rflush_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rflush_rdy", {31'd0, bus.in_ready}, 32'd1);

        // Flush in IDLE rejects a same-cycle request.
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        chk("iflush_req", {31'd0, bus.mem_req}, 32'd0);
        chk("iflush_rdy", {31'd0, bus.in_ready}, 32'd1);

        // Flush in OUT drops the result.
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.mem_gnt  = 1'b1;
        step();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        step();
        bus.mem_rvalid = 1'b0;
        chk("oflush_pre", {31'd0, bus.out_valid}, 32'd1);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("oflush_ovalid", {31'd0, bus.out_valid}, 32'd0);
        chk("oflush_rdy", {31'd0, bus.in_ready}, 32'd1);

        // Reset while in REQ, then a stray rvalid.
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        bus.mem_gnt  = 1'b1;
        step();
        bus.mem_gnt = 1'b0;
        reset       = 1'b0;
        chk("rreq_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rreq_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
        chk("rreq_rdy", {31'd0, bus.in_ready}, 32'd0);
        chk("rreq_pix", {24'd0, bus.pix_index}, 32'd0);
        step();
        chk("rreq_rdy_back", {31'd0, bus.in_ready}, 32'd1);
        bus.mem_rvalid = 1'b1;
        step();
        bus.mem_rvalid = 1'b0;
        chk("rreq_stray_ovalid", {31'd0, bus.out_valid}, 32'd0);
        chk("rreq_stray_req", {31'd0, bus.mem_req}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
